square_writer: RTL

Inverse companion to the odd-subtraction square-root unit. On a start pulse, the block sweeps addresses 0..15. At each address it reads a 4-bit root, forms its 8-bit square by accumulating successive odd numbers (1+3+5+…), and writes the result to the 16×8 result RAM at the same address. It fills the lab RAM with square values that the square-root unit later reads back.

---
 rtl/square_writer.sv | 105 ++++++++++
 1 files changed

// File: rtl/square_writer.sv
// Fills a 16x8 RAM with squares of 4-bit roots, summing successive odd numbers.
// Build option SQUARE_SELF_SEED_EN: use the address itself as the root instead of RDI.
module square_writer (
    input  logic       CLK,
    input  logic       RST,
    input  logic       St,
    input  logic [3:0] RDI,
    output logic [3:0] Addr,
    output logic [7:0] MDO,
    output logic       WE,
    output logic       Busy,
    output logic       Done
);

    typedef enum logic [1:0] {IDLE, LOAD, ACC, WRITE} state_t;

    state_t     state, state_nxt;
    logic [3:0] n, n_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic [7:0] odd, odd_nxt;
    logic [7:0] acc, acc_nxt;
    logic [3:0] addr_nxt;
    logic [7:0] mdo_nxt;
    logic       we_nxt;
    logic       done_nxt;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
            n     <= '0;
            cnt   <= '0;
            odd   <= 8'd1;
            acc   <= '0;
            Addr  <= '0;
            MDO   <= '0;
            WE    <= 1'b0;
            Done  <= 1'b0;
        end else begin
            state <= state_nxt;
            n     <= n_nxt;
            cnt   <= cnt_nxt;
            odd   <= odd_nxt;
            acc   <= acc_nxt;
            Addr  <= addr_nxt;
            MDO   <= mdo_nxt;
            WE    <= we_nxt;
            Done  <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        n_nxt     = n;
        cnt_nxt   = cnt;
        odd_nxt   = odd;
        acc_nxt   = acc;
        addr_nxt  = Addr;
        mdo_nxt   = MDO;
        we_nxt    = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (St)
                    state_nxt = LOAD;
            end
            LOAD: begin
`ifdef SQUARE_SELF_SEED_EN
                n_nxt = Addr;
`else
                n_nxt = RDI;
`endif
                acc_nxt   = '0;
                odd_nxt   = 8'd1;
                cnt_nxt   = '0;
                state_nxt = ACC;
            end
            ACC: begin
                // The n-th partial sum of odd numbers is n squared.
                if (cnt < n) begin
                    acc_nxt = acc + odd;
                    odd_nxt = odd + 8'd2;
                    cnt_nxt = cnt + 4'd1;
                end else begin
                    mdo_nxt   = acc;
                    we_nxt    = 1'b1;
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                if (Addr == 4'd15) begin
                    addr_nxt  = '0;
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    addr_nxt  = Addr + 4'd1;
                    state_nxt = LOAD;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign Busy = (state != IDLE);

endmodule
